// File: rtl/decode_pkg.sv
// Shared definitions for the decode stage.
// Contents: RV32I major opcodes, one-hot ALU operation codes,
// mem_hb access-size encodings, the decoded-word record and a
// helper that turns funct3 into a one-hot ALU op.
package decode_pkg;

  typedef enum logic [6:0] {
    OPC_LOAD     = 7'h03,
    OPC_MISC_MEM = 7'h0F,
    OPC_OP_IMM   = 7'h13,
    OPC_AUIPC    = 7'h17,
    OPC_STORE    = 7'h23,
    OPC_OP       = 7'h33,
    OPC_LUI      = 7'h37,
    OPC_BRANCH   = 7'h63,
    OPC_JALR     = 7'h67,
    OPC_JAL      = 7'h6F,
    OPC_SYSTEM   = 7'h73
  } opcode_e;

  // One-hot ALU op, bit index equals funct3
  localparam logic [7:0] ALU_ADD  = 8'h01;
  localparam logic [7:0] ALU_SLL  = 8'h02;
  localparam logic [7:0] ALU_SLT  = 8'h04;
  localparam logic [7:0] ALU_SLTU = 8'h08;
  localparam logic [7:0] ALU_XOR  = 8'h10;
  localparam logic [7:0] ALU_SR   = 8'h20;
  localparam logic [7:0] ALU_OR   = 8'h40;
  localparam logic [7:0] ALU_AND  = 8'h80;

  localparam logic [1:0] MEM_HB_BYTE = 2'b00;
  localparam logic [1:0] MEM_HB_HALF = 2'b01;
  localparam logic [1:0] MEM_HB_WORD = 2'b10;

  typedef struct packed {
    logic [31:0] instruction;
    logic [31:0] pc;
    logic [4:0]  rd_ptr;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [7:0]  funct3I;
    logic [6:0]  funct7;
    logic        alu_src;
    logic        reg_we;
    logic        mem_we;
    logic        mem_re;
    logic [1:0]  mem_hb;
    logic        mem_ul;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        illegal;
  } dec_t;

  function automatic logic [7:0] alu_onehot(input logic [2:0] funct3);
    return ALU_ADD << funct3;
  endfunction

endpackage

// File: rtl/decode_if.sv
// Decode stage bus: fetched word, pipeline control, writeback port
// and the registered decode results.
// slave  : used by the decode block (consumes *_i, drives *_o)
// master : used by the surrounding pipeline / testbench
interface decode_if;
  logic [31:0] instruction_i;
  logic [31:0] program_pointer_i;
  logic        stall_i;
  logic        flush_i;
  logic [31:0] wb_rd_i;
  logic [4:0]  wb_rd_ptr_i;
  logic        wb_reg_we_i;

  logic [31:0] instruction_o;
  logic [31:0] program_pointer_o;
  logic [4:0]  rd_ptr_o;
  logic [31:0] rs1_o;
  logic [31:0] rs2_o;
  logic [31:0] imm_o;
  logic [7:0]  funct3I_o;
  logic [6:0]  funct7_o;
  logic        alu_src_o;
  logic        reg_we_o;
  logic        mem_we_o;
  logic        mem_re_o;
  logic [1:0]  mem_hb_o;
  logic        mem_ul_o;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;
  logic        illegal_o;

  modport slave (
    input  instruction_i, program_pointer_i, stall_i, flush_i,
           wb_rd_i, wb_rd_ptr_i, wb_reg_we_i,
    output instruction_o, program_pointer_o, rd_ptr_o, rs1_o, rs2_o, imm_o,
           funct3I_o, funct7_o, alu_src_o, reg_we_o, mem_we_o, mem_re_o,
           mem_hb_o, mem_ul_o, redirect_o, redirect_pc_o, illegal_o
  );

  modport master (
    output instruction_i, program_pointer_i, stall_i, flush_i,
           wb_rd_i, wb_rd_ptr_i, wb_reg_we_i,
    input  instruction_o, program_pointer_o, rd_ptr_o, rs1_o, rs2_o, imm_o,
           funct3I_o, funct7_o, alu_src_o, reg_we_o, mem_we_o, mem_re_o,
           mem_hb_o, mem_ul_o, redirect_o, redirect_pc_o, illegal_o
  );
endinterface

// File: rtl/decode_regfile.sv
// 32x32 integer register file with two read ports and one write port.
// Ports: clk_i, rst_ni (async, active-low, clears all registers),
//        rs1/rs2 read address + data, wr_addr/wr_data/wr_en write port.
// x0 always reads 0 and ignores writes. A write in the same cycle as a
// read of the same register is forwarded to the read port.
module regfile (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [4:0]  rs1_addr_i,
  input  logic [4:0]  rs2_addr_i,
  output logic [31:0] rs1_data_o,
  output logic [31:0] rs2_data_o,
  input  logic [4:0]  wr_addr_i,
  input  logic [31:0] wr_data_i,
  input  logic        wr_en_i
);
  logic [31:0] regs_q [32];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (wr_en_i && (wr_addr_i != 5'd0)) begin
      regs_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rs1_data_o = (rs1_addr_i == 5'd0) ? 32'd0 :
                      (wr_en_i && (wr_addr_i == rs1_addr_i)) ? wr_data_i :
                      regs_q[rs1_addr_i];
  assign rs2_data_o = (rs2_addr_i == 5'd0) ? 32'd0 :
                      (wr_en_i && (wr_addr_i == rs2_addr_i)) ? wr_data_i :
                      regs_q[rs2_addr_i];
endmodule

// File: rtl/decode.sv
// RV32I decode stage: combinational decode of the fetched word feeding
// one output register. Resolves branches and jumps here (redirect_o).
// Ports: clk_i, rst_ni (async, active-low) and the decode_if slave bus
// carrying instruction/pc, stall/flush, writeback and decoded outputs.
// A cleared output register is a bubble (no enables, no redirect).
module decode
  import decode_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_ni,
  decode_if.slave  bus
);
  logic [31:0] instr, pc;
  logic [2:0]  funct3;
  logic [31:0] rs1_val, rs2_val;
  logic signed [31:0] rs1_s, rs2_s;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        bubble, illegal, taken;
  dec_t        dec_d, dec_q;

  assign instr  = bus.instruction_i;
  assign pc     = bus.program_pointer_i;
  assign funct3 = instr[14:12];
  assign rs1_s  = rs1_val;
  assign rs2_s  = rs2_val;

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  regfile u_regfile (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .rs1_addr_i (instr[19:15]),
    .rs2_addr_i (instr[24:20]),
    .rs1_data_o (rs1_val),
    .rs2_data_o (rs2_val),
    .wr_addr_i  (bus.wb_rd_ptr_i),
    .wr_data_i  (bus.wb_rd_i),
    .wr_en_i    (bus.wb_reg_we_i)
  );

  always_comb begin
    dec_d             = '0;
    bubble            = 1'b0;
    illegal           = 1'b0;
    taken             = 1'b0;
    dec_d.instruction = instr;
    dec_d.pc          = pc;
    dec_d.rd_ptr      = instr[11:7];
    dec_d.rs1         = rs1_val;
    dec_d.alu_src     = 1'b1;
    dec_d.funct3I     = ALU_ADD;
    case (instr[6:0])
      OPC_OP: begin
        dec_d.rs2     = rs2_val;
        dec_d.funct3I = alu_onehot(funct3);
        dec_d.funct7  = instr[31:25];
        dec_d.alu_src = 1'b0;
        dec_d.reg_we  = 1'b1;
      end
      OPC_OP_IMM: begin
        dec_d.imm     = imm_i;
        dec_d.funct3I = alu_onehot(funct3);
        // Only shifts carry meaning in the upper immediate bits
        if (funct3 == 3'b001 || funct3 == 3'b101) dec_d.funct7 = instr[31:25];
        dec_d.reg_we  = 1'b1;
      end
      OPC_LOAD: begin
        dec_d.imm    = imm_i;
        dec_d.reg_we = 1'b1;
        dec_d.mem_re = 1'b1;
        dec_d.mem_hb = funct3[1:0];
        dec_d.mem_ul = funct3[2];
      end
      OPC_STORE: begin
        dec_d.imm    = imm_s;
        dec_d.rs2    = rs2_val;
        dec_d.mem_we = 1'b1;
        dec_d.mem_hb = funct3[1:0];
      end
      OPC_LUI: begin
        dec_d.rs1    = '0;
        dec_d.imm    = imm_u;
        dec_d.reg_we = 1'b1;
      end
      OPC_AUIPC: begin
        dec_d.rs1    = pc;
        dec_d.imm    = imm_u;
        dec_d.reg_we = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        // Link value pc+4 is computed by the ALU from rs1=pc, imm=4
        dec_d.rs1         = pc;
        dec_d.imm         = 32'd4;
        dec_d.reg_we      = 1'b1;
        dec_d.redirect    = 1'b1;
        dec_d.redirect_pc = (instr[6:0] == OPC_JAL) ? (pc + imm_j)
                                                    : ((rs1_val + imm_i) & ~32'd1);
      end
      OPC_BRANCH: begin
        dec_d.rs2     = rs2_val;
        dec_d.imm     = imm_b;
        dec_d.funct3I = '0;
        case (funct3)
          3'b000:  taken = (rs1_val == rs2_val);
          3'b001:  taken = (rs1_val != rs2_val);
          3'b100:  taken = (rs1_s < rs2_s);
          3'b101:  taken = (rs1_s >= rs2_s);
          3'b110:  taken = (rs1_val < rs2_val);
          3'b111:  taken = (rs1_val >= rs2_val);
          default: illegal = 1'b1;
        endcase
        if (taken) begin
          dec_d.redirect    = 1'b1;
          dec_d.redirect_pc = pc + imm_b;
        end
      end
      OPC_MISC_MEM, OPC_SYSTEM: bubble = 1'b1;
      default: illegal = 1'b1;
    endcase
    if (instr[11:7] == 5'd0) dec_d.reg_we = 1'b0;
    if (bubble || illegal) begin
      dec_d         = '0;
      dec_d.illegal = illegal;
    end
  end

  // ---- output register stage ----
  // A redirect in the register means the word now presented is on the
  // wrong path, so the next load is replaced by a bubble.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dec_q <= '0;
    end else if (bus.flush_i) begin
      dec_q <= '0;
    end else if (!bus.stall_i) begin
      dec_q <= dec_q.redirect ? '0 : dec_d;
    end
  end

  assign bus.instruction_o     = dec_q.instruction;
  assign bus.program_pointer_o = dec_q.pc;
  assign bus.rd_ptr_o          = dec_q.rd_ptr;
  assign bus.rs1_o             = dec_q.rs1;
  assign bus.rs2_o             = dec_q.rs2;
  assign bus.imm_o             = dec_q.imm;
  assign bus.funct3I_o         = dec_q.funct3I;
  assign bus.funct7_o          = dec_q.funct7;
  assign bus.alu_src_o         = dec_q.alu_src;
  assign bus.reg_we_o          = dec_q.reg_we;
  assign bus.mem_we_o          = dec_q.mem_we;
  assign bus.mem_re_o          = dec_q.mem_re;
  assign bus.mem_hb_o          = dec_q.mem_hb;
  assign bus.mem_ul_o          = dec_q.mem_ul;
  assign bus.redirect_o        = dec_q.redirect;
  assign bus.redirect_pc_o     = dec_q.redirect_pc;
  assign bus.illegal_o         = dec_q.illegal;
endmodule

// File: tb/tb_decode.sv
// Self-checking bench for the decode stage: a vector table of RV32I
// words with hand-derived expected decodes, plus sequences for stall,
// flush, x0 writeback and asynchronous reset.
module tb_decode;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  decode_if bus ();

  decode u_dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [7:0]  f3;
    logic [6:0]  f7;
    logic        src;
    logic        rwe;
    logic        mwe;
    logic        mre;
    logic [1:0]  hb;
    logic        ul;
    logic        redir;
    logic [31:0] rpc;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        wb_we;
    logic [4:0]  wb_ptr;
    logic [31:0] wb_data;
    exp_t        exp;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic exp_t E(input logic [4:0] rd, input logic [31:0] rs1, rs2, imm,
                             input logic [7:0] f3, input logic [6:0] f7,
                             input logic src, rwe, mwe, mre, input logic [1:0] hb,
                             input logic ul, redir, input logic [31:0] rpc, input logic ill);
    exp_t e;
    e = '0;
    e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.imm = imm; e.f3 = f3; e.f7 = f7;
    e.src = src; e.rwe = rwe; e.mwe = mwe; e.mre = mre; e.hb = hb; e.ul = ul;
    e.redir = redir; e.rpc = rpc; e.ill = ill;
    return e;
  endfunction

  function automatic exp_t bub(input logic ill);
    exp_t e;
    e = '0;
    e.ill = ill;
    return e;
  endfunction

  // live=1: the word passes through, so instruction_o/program_pointer_o echo it
  function automatic vec_t V(input logic [31:0] instr, pc, input logic we,
                             input logic [4:0] ptr, input logic [31:0] data,
                             input logic live, input exp_t e);
    vec_t v;
    v.instr = instr; v.pc = pc; v.wb_we = we; v.wb_ptr = ptr; v.wb_data = data;
    v.exp = e;
    v.exp.instr = live ? instr : 32'd0;
    v.exp.pc    = live ? pc : 32'd0;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic check_pop(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, got output with nothing expected", tag);
      return;
    end
    e = sb.pop_front();
    chk({tag, ".instr"},  bus.instruction_o,     e.instr);
    chk({tag, ".pc"},     bus.program_pointer_o, e.pc);
    chk({tag, ".rd"},     32'(bus.rd_ptr_o),     32'(e.rd));
    chk({tag, ".rs1"},    bus.rs1_o,             e.rs1);
    chk({tag, ".rs2"},    bus.rs2_o,             e.rs2);
    chk({tag, ".imm"},    bus.imm_o,             e.imm);
    chk({tag, ".f3I"},    32'(bus.funct3I_o),    32'(e.f3));
    chk({tag, ".f7"},     32'(bus.funct7_o),     32'(e.f7));
    chk({tag, ".src"},    32'(bus.alu_src_o),    32'(e.src));
    chk({tag, ".rwe"},    32'(bus.reg_we_o),     32'(e.rwe));
    chk({tag, ".mwe"},    32'(bus.mem_we_o),     32'(e.mwe));
    chk({tag, ".mre"},    32'(bus.mem_re_o),     32'(e.mre));
    chk({tag, ".hb"},     32'(bus.mem_hb_o),     32'(e.hb));
    chk({tag, ".ul"},     32'(bus.mem_ul_o),     32'(e.ul));
    chk({tag, ".redir"},  32'(bus.redirect_o),   32'(e.redir));
    chk({tag, ".rpc"},    bus.redirect_pc_o,     e.rpc);
    chk({tag, ".ill"},    32'(bus.illegal_o),    32'(e.ill));
  endtask

  task automatic drive(input logic [31:0] instr, pc, input logic stall, flush,
                       input logic we, input logic [4:0] ptr, input logic [31:0] data);
    bus.instruction_i     = instr;
    bus.program_pointer_i = pc;
    bus.stall_i           = stall;
    bus.flush_i           = flush;
    bus.wb_reg_we_i       = we;
    bus.wb_rd_ptr_i       = ptr;
    bus.wb_rd_i           = data;
  endtask

  initial begin
    exp_t a;
    // ---- vector table ----
    vecs.push_back(V(32'h00500093, 32'h10,  0, 0, 0,            1, E(1, 0, 0, 5, 8'h01, 0, 1,1,0,0, 2'b00,0, 0, 0, 0)));          // ADDI x1,x0,5
    vecs.push_back(V(32'h000101B3, 32'h14,  1, 2, 32'hDEADBEEF, 1, E(3, 32'hDEADBEEF, 0, 0, 8'h01, 0, 0,1,0,0, 2'b00,0, 0, 0, 0))); // ADD x3,x2,x0 + bypass
    vecs.push_back(V(32'hFFF0C203, 32'h18,  1, 1, 32'h1000,     1, E(4, 32'h1000, 0, 32'hFFFFFFFF, 8'h01, 0, 1,1,0,1, 2'b00,1, 0, 0, 0))); // LBU x4,-1(x1)
    vecs.push_back(V(32'h0020A423, 32'h1C,  0, 0, 0,            1, E(8, 32'h1000, 32'hDEADBEEF, 8, 8'h01, 0, 1,0,1,0, 2'b10,0, 0, 0, 0))); // SW x2,8(x1)
    vecs.push_back(V(32'h123452B7, 32'h20,  0, 0, 0,            1, E(5, 0, 0, 32'h12345000, 8'h01, 0, 1,1,0,0, 2'b00,0, 0, 0, 0)));  // LUI
    vecs.push_back(V(32'hFFFFF317, 32'h200, 0, 0, 0,            1, E(6, 32'h200, 0, 32'hFFFFF000, 8'h01, 0, 1,1,0,0, 2'b00,0, 0, 0, 0))); // AUIPC
    vecs.push_back(V(32'h40415393, 32'h24,  0, 0, 0,            1, E(7, 32'hDEADBEEF, 0, 32'h404, 8'h20, 7'h20, 1,1,0,0, 2'b00,0, 0, 0, 0))); // SRAI x7,x2,4
    vecs.push_back(V(32'h40210033, 32'h28,  0, 0, 0,            1, E(0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 8'h01, 7'h20, 0,0,0,0, 2'b00,0, 0, 0, 0))); // SUB x0 -> no we
    vecs.push_back(V(32'h00000463, 32'h100, 0, 0, 0,            1, E(8, 0, 0, 8, 8'h00, 0, 1,0,0,0, 2'b00,0, 1, 32'h108, 0)));      // BEQ x0,x0,+8
    vecs.push_back(V(32'h00100493, 32'h104, 0, 0, 0,            0, bub(0)));                                                          // wrong path
    vecs.push_back(V(32'h010000EF, 32'h300, 0, 0, 0,            1, E(1, 32'h300, 0, 4, 8'h01, 0, 1,1,0,0, 2'b00,0, 1, 32'h310, 0)));  // JAL x1,+16
    vecs.push_back(V(32'h00500093, 32'h304, 0, 0, 0,            0, bub(0)));
    vecs.push_back(V(32'h00308067, 32'h400, 0, 0, 0,            1, E(0, 32'h400, 0, 4, 8'h01, 0, 1,0,0,0, 2'b00,0, 1, 32'h1002, 0))); // JALR x0,3(x1)
    vecs.push_back(V(32'h00500093, 32'h404, 0, 0, 0,            0, bub(0)));
    vecs.push_back(V(32'hFE114EE3, 32'h500, 0, 0, 0,            1, E(29, 32'hDEADBEEF, 32'h1000, 32'hFFFFFFFC, 8'h00, 0, 1,0,0,0, 2'b00,0, 1, 32'h4FC, 0))); // BLT taken
    vecs.push_back(V(32'h00500093, 32'h4FC, 0, 0, 0,            0, bub(0)));
    vecs.push_back(V(32'hFE116EE3, 32'h504, 0, 0, 0,            1, E(29, 32'hDEADBEEF, 32'h1000, 32'hFFFFFFFC, 8'h00, 0, 1,0,0,0, 2'b00,0, 0, 0, 0))); // BLTU not taken
    vecs.push_back(V(32'h0000000F, 32'h508, 0, 0, 0,            0, bub(0)));  // FENCE
    vecs.push_back(V(32'h0000007F, 32'h50C, 0, 0, 0,            0, bub(1)));  // unknown opcode
    vecs.push_back(V(32'h00002063, 32'h510, 0, 0, 0,            0, bub(1)));  // BRANCH funct3=010
    vecs.push_back(V(32'h00000073, 32'h514, 0, 0, 0,            0, bub(0)));  // ECALL
    vecs.push_back(V(32'h00209503, 32'h518, 0, 0, 0,            1, E(10, 32'h1000, 0, 2, 8'h01, 0, 1,1,0,1, 2'b01,0, 0, 0, 0))); // LH x10,2(x1)

    // ---- reset state ----
    rst_n = 1'b0;
    drive(32'h00500093, 32'h10, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    sb.push_back(bub(0));
    check_pop("reset");
    rst_n = 1'b1;

    // ---- table ----
    foreach (vecs[i]) begin
      drive(vecs[i].instr, vecs[i].pc, 0, 0, vecs[i].wb_we, vecs[i].wb_ptr, vecs[i].wb_data);
      sb.push_back(vecs[i].exp);
      @(negedge clk);
      check_pop($sformatf("v%0d", i));
    end

    // ---- stall holds, then flush overrides stall ----
    a = E(1, 0, 0, 5, 8'h01, 0, 1,1,0,0, 2'b00,0, 0, 0, 0);
    a.instr = 32'h00500093; a.pc = 32'h600;
    drive(32'h00500093, 32'h600, 0, 0, 0, 0, 0);
    sb.push_back(a);
    @(negedge clk);
    check_pop("stall_load");
    for (int k = 0; k < 3; k++) begin
      drive($urandom, $urandom, 1, 0, 0, 0, 0);
      sb.push_back(a);
      @(negedge clk);
      check_pop($sformatf("stall%0d", k));
    end
    drive(32'h000101B3, 32'h604, 1, 1, 0, 0, 0);
    sb.push_back(bub(0));
    @(negedge clk);
    check_pop("flush");

    // ---- write to x0 is ignored, x0 reads 0 (with and without bypass) ----
    a = E(11, 0, 0, 0, 8'h01, 0, 0,1,0,0, 2'b00,0, 0, 0, 0);
    a.instr = 32'h000005B3; a.pc = 32'h700;
    drive(32'h000005B3, 32'h700, 0, 0, 1, 0, 32'h55);
    sb.push_back(a);
    @(negedge clk);
    check_pop("x0_wr");
    drive(32'h000005B3, 32'h700, 0, 0, 0, 0, 0);
    sb.push_back(a);
    @(negedge clk);
    check_pop("x0_rd");

    // ---- asynchronous reset mid-stream, regfile cleared ----
    a = E(3, 32'hDEADBEEF, 0, 0, 8'h01, 0, 0,1,0,0, 2'b00,0, 0, 0, 0);
    a.instr = 32'h000101B3; a.pc = 32'h800;
    drive(32'h000101B3, 32'h800, 0, 0, 0, 0, 0);
    sb.push_back(a);
    @(negedge clk);
    check_pop("pre_rst");
    #2 rst_n = 1'b0;
    #1;
    sb.push_back(bub(0));
    check_pop("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    a.rs1 = 32'd0;
    sb.push_back(a);
    @(negedge clk);
    check_pop("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
